// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, reset PC,
// FSM state encoding and the buffered {pc, instruction} entry.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, instruction} entries with push, pop,
// flush and an occupancy count.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head_c,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a
// small decode queue, with redirect (flush + stale-response discard).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic          r_req;
  logic          w_req_nxt;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ_pop;
  logic [CW-1:0] w_occ_push;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  assign w_pop       = id_valid && id_ready && !redirect_valid;
  assign w_occ_pop   = w_count - CW'(w_pop);
  assign w_occ_push  = w_occ_pop + CW'(1);
  assign w_push_data = '{pc: r_fetch_pc, insn: imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
    end
  end

  // Next state; redirect overrides push and PC increment.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_valid || (w_occ_pop < CW'(QUEUE_DEPTH))) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? S_REQ : S_DISCARD;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = (w_occ_push < CW'(QUEUE_DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (redirect_valid) w_fetch_pc_nxt = redirect_pc & ~32'd3;
    w_req_nxt  = (w_state_nxt != S_IDLE);
    // A discarded request keeps presenting its original address until acked.
    w_addr_nxt = (w_state_nxt == S_DISCARD) ? r_addr : w_fetch_pc_nxt;
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (redirect_valid),
    .i_data   (w_push_data),
    .o_head_c (w_head),
    .o_count  (w_count)
  );

  assign imem_req       = r_req;
  assign imem_addr      = r_addr;
  assign id_valid       = (w_count != '0);
  assign id_instruction = id_valid ? w_head.insn : NOP_INSN;
  assign id_pc          = id_valid ? w_head.pc : 32'd0;

endmodule
